// File: rtl/filter_frame_sequencer.sv
// Purpose : sequences one filter frame: optional coefficient load, ROW_WIDTH x COL_WIDTH
//           pixel stream, drain until the filter has produced every output (or timeout).
// Latency : each accepted coef/pixel beat appears on f_data* exactly one cycle later.
// Backpr. : valid/ready; coef_ready only in LOAD_COEF, pix_ready only in STREAM; a
//           deasserted valid simply stalls the counters.
// Ports   : clk/reset_in (async active-low); start + reload_coef (frame request);
//           coef_valid/coef_data/coef_ready and pix_valid/pix_data/pix_ready (inputs);
//           f_data_valid/f_data/f_data_id (to filter, id 0 = coef, 1 = pixel);
//           f_pix_out_valid (filter output strobe); busy, frame_done, timeout_err, out_cnt.
module filter_frame_sequencer #(
  parameter int DATA_BIT   = 15,
  parameter int DATA_IDBIT = 1,
  parameter int ROW_WIDTH  = 640,
  parameter int COL_WIDTH  = 480,
  parameter int MASK_WIDTH = 7,
  parameter int CNT_BIT    = 10,
  parameter int COFCNT_BIT = 15,
  parameter int PIX_BIT    = 8,
  parameter int DRAIN_MAX  = 4095
) (
  input  logic                  clk,
  input  logic                  reset_in,
  input  logic                  start,
  input  logic                  reload_coef,
  input  logic                  coef_valid,
  input  logic [COFCNT_BIT-1:0] coef_data,
  output logic                  coef_ready,
  input  logic                  pix_valid,
  input  logic [PIX_BIT-1:0]    pix_data,
  output logic                  pix_ready,
  output logic                  f_data_valid,
  output logic [DATA_BIT-1:0]   f_data,
  output logic [DATA_IDBIT-1:0] f_data_id,
  input  logic                  f_pix_out_valid,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  timeout_err,
  output logic [2*CNT_BIT-1:0]  out_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int COEF_NUM  = MASK_WIDTH * MASK_WIDTH;
  localparam int COEF_CBIT = $clog2(COEF_NUM + 1);
  localparam int DRN_BIT   = $clog2(DRAIN_MAX + 1);
  localparam int OCNT_BIT  = 2 * CNT_BIT;

  localparam logic [COEF_CBIT-1:0] COEF_LAST = COEF_CBIT'(COEF_NUM - 1);
  localparam logic [CNT_BIT-1:0]   COL_LAST  = CNT_BIT'(ROW_WIDTH - 1);
  localparam logic [CNT_BIT-1:0]   ROW_LAST  = CNT_BIT'(COL_WIDTH - 1);
  localparam logic [OCNT_BIT-1:0]  FRAME_PIX = OCNT_BIT'(ROW_WIDTH * COL_WIDTH);
  localparam logic [DRN_BIT-1:0]   DRN_LAST  = DRN_BIT'(DRAIN_MAX - 1);

  logic [2:0]            state_q, state_d;
  logic [COEF_CBIT-1:0]  coef_cnt_q, coef_cnt_d;
  logic [CNT_BIT-1:0]    col_q, col_d;
  logic [CNT_BIT-1:0]    row_q, row_d;
  logic [OCNT_BIT-1:0]   out_cnt_q, out_cnt_d;
  logic [DRN_BIT-1:0]    drn_q, drn_d;
  logic                  timeout_q, timeout_d;
  logic                  f_vld_q, f_vld_d;
  logic [DATA_BIT-1:0]   f_dat_q, f_dat_d;
  logic [DATA_IDBIT-1:0] f_id_q, f_id_d;

  logic                  coef_xfer;
  logic                  pix_xfer;
  logic                  out_inc;
  logic [OCNT_BIT-1:0]   out_cnt_nxt;

  assign coef_xfer   = (state_q == S_LOAD) && coef_valid;
  assign pix_xfer    = (state_q == S_STREAM) && pix_valid;
  // Filter strobes only count while a frame is in flight; saturate instead of wrapping.
  assign out_inc     = f_pix_out_valid && (state_q inside {S_LOAD, S_STREAM, S_DRAIN})
                       && (out_cnt_q != '1);
  assign out_cnt_nxt = out_cnt_q + OCNT_BIT'(out_inc);

  always_comb begin
    state_d    = state_q;
    coef_cnt_d = coef_cnt_q;
    col_d      = col_q;
    row_d      = row_q;
    out_cnt_d  = out_cnt_nxt;
    drn_d      = '0;            // drain counter only runs inside DRAIN
    timeout_d  = timeout_q;
    f_vld_d    = 1'b0;
    f_dat_d    = '0;
    f_id_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = reload_coef ? S_LOAD : S_STREAM;
          coef_cnt_d = '0;
          col_d      = '0;
          row_d      = '0;
          out_cnt_d  = '0;
          timeout_d  = 1'b0;
        end
      end
      S_LOAD: begin
        if (coef_xfer) begin
          f_vld_d    = 1'b1;
          f_dat_d    = DATA_BIT'(coef_data);
          f_id_d     = '0;
          coef_cnt_d = coef_cnt_q + 1'b1;   // stops at COEF_NUM: state leaves here
          if (coef_cnt_q == COEF_LAST) state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (pix_xfer) begin
          f_vld_d = 1'b1;
          f_dat_d = DATA_BIT'(pix_data);
          f_id_d  = DATA_IDBIT'(1);
          if (col_q == COL_LAST) begin
            if (row_q == ROW_LAST) begin
              // Last pixel: counters hold at their terminal values.
              state_d = S_DRAIN;
            end else begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        drn_d = drn_q + 1'b1;
        // A completed frame takes priority over a timeout landing in the same cycle.
        if (out_cnt_nxt >= FRAME_PIX) begin
          state_d = S_DONE;
        end else if (drn_q == DRN_LAST) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_q    <= S_IDLE;
      coef_cnt_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      out_cnt_q  <= '0;
      drn_q      <= '0;
      timeout_q  <= 1'b0;
      f_vld_q    <= 1'b0;
      f_dat_q    <= '0;
      f_id_q     <= '0;
    end else begin
      state_q    <= state_d;
      coef_cnt_q <= coef_cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      out_cnt_q  <= out_cnt_d;
      drn_q      <= drn_d;
      timeout_q  <= timeout_d;
      f_vld_q    <= f_vld_d;
      f_dat_q    <= f_dat_d;
      f_id_q     <= f_id_d;
    end
  end

  assign coef_ready   = (state_q == S_LOAD);
  assign pix_ready    = (state_q == S_STREAM);
  assign busy         = (state_q != S_IDLE);
  assign frame_done   = (state_q == S_DONE);
  assign timeout_err  = timeout_q;
  assign out_cnt      = out_cnt_q;
  assign f_data_valid = f_vld_q;
  assign f_data       = f_dat_q;
  assign f_data_id    = f_id_q;

endmodule

// File: tb/tb_filter_frame_sequencer.sv
// Purpose : self-checking bench for filter_frame_sequencer on a 4x3 frame, 7x7 mask,
//           16-cycle drain limit, with random data and random pixel valid gaps.
// Latency : expects every accepted beat on f_data* exactly one cycle after acceptance.
// Backpr. : pixel valid toggles randomly; coef valid is held high throughout.
`timescale 1ns/1ps
module tb_filter_frame_sequencer;

  localparam int DATA_BIT   = 15;
  localparam int DATA_IDBIT = 1;
  localparam int ROW_WIDTH  = 4;
  localparam int COL_WIDTH  = 3;
  localparam int MASK_WIDTH = 7;
  localparam int CNT_BIT    = 10;
  localparam int COFCNT_BIT = 15;
  localparam int PIX_BIT    = 8;
  localparam int DRAIN_MAX  = 16;
  localparam int PIXELS     = ROW_WIDTH * COL_WIDTH;
  localparam int COEFS      = MASK_WIDTH * MASK_WIDTH;

  logic                  clk = 1'b0;
  logic                  reset_in;
  logic                  start;
  logic                  reload_coef;
  logic                  coef_valid;
  logic [COFCNT_BIT-1:0] coef_data;
  logic                  coef_ready;
  logic                  pix_valid;
  logic [PIX_BIT-1:0]    pix_data;
  logic                  pix_ready;
  logic                  f_data_valid;
  logic [DATA_BIT-1:0]   f_data;
  logic [DATA_IDBIT-1:0] f_data_id;
  logic                  f_pix_out_valid;
  logic                  busy;
  logic                  frame_done;
  logic                  timeout_err;
  logic [2*CNT_BIT-1:0]  out_cnt;

  always #5 clk = ~clk;

  filter_frame_sequencer #(
    .DATA_BIT(DATA_BIT), .DATA_IDBIT(DATA_IDBIT), .ROW_WIDTH(ROW_WIDTH),
    .COL_WIDTH(COL_WIDTH), .MASK_WIDTH(MASK_WIDTH), .CNT_BIT(CNT_BIT),
    .COFCNT_BIT(COFCNT_BIT), .PIX_BIT(PIX_BIT), .DRAIN_MAX(DRAIN_MAX)
  ) dut (
    .clk(clk), .reset_in(reset_in), .start(start), .reload_coef(reload_coef),
    .coef_valid(coef_valid), .coef_data(coef_data), .coef_ready(coef_ready),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .f_data_valid(f_data_valid), .f_data(f_data), .f_data_id(f_data_id),
    .f_pix_out_valid(f_pix_out_valid), .busy(busy), .frame_done(frame_done),
    .timeout_err(timeout_err), .out_cnt(out_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Observations collected by run_frame for the calling test to judge.
  logic [15:0] r_obs[$];
  logic [15:0] r_exp[$];
  int   r_lat_err, r_coef_rdy, r_coef_vld, r_first_coef, r_last_coef;
  int   r_last_coef_push, r_stream_at, r_drain, r_glitch_err;
  bit   r_done_seen, r_rdy_after_last, r_to_at_done, r_done_after, r_busy_after;
  bit   r_to_after_start;
  logic [2*CNT_BIT-1:0] r_out_cnt;

  // Drives one whole frame and models the filter: one output strobe per pixel seen
  // on f_data (up to n_strobes). Expected beats are queued in acceptance order.
  task automatic run_frame(input bit reload, input int n_strobes, input bit inject_start);
    bit pend = 1'b0;
    logic [15:0] pend_beat = '0;
    int npix = 0;
    int ncoef = 0;
    int sent = 0;
    bit chk_rdy = 1'b0;
    bit chk_glitch = 1'b0;
    bit injected = 1'b0;
    bit done = 1'b0;
    r_obs.delete();
    r_exp.delete();
    r_lat_err = 0; r_coef_rdy = 0; r_coef_vld = 0; r_first_coef = -1; r_last_coef = -1;
    r_last_coef_push = -1; r_stream_at = -1; r_drain = 0; r_glitch_err = 0;
    r_done_seen = 0; r_rdy_after_last = 1; r_to_at_done = 0; r_out_cnt = '0;
    @(negedge clk);
    start = 1'b1; reload_coef = reload;
    @(negedge clk);
    start = 1'b0; reload_coef = 1'b0;
    r_to_after_start = timeout_err;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (f_data_valid !== pend) r_lat_err++;
      else if (pend && ({f_data_id, f_data} !== pend_beat)) r_lat_err++;
      if (f_data_valid === 1'b1) begin
        r_obs.push_back({f_data_id, f_data});
        if (f_data_id === 1'b0) begin
          r_coef_vld++;
          if (r_first_coef < 0) r_first_coef = cyc;
          r_last_coef = cyc;
        end
      end
      if (coef_ready === 1'b1) r_coef_rdy++;
      if (pix_ready === 1'b1 && r_stream_at < 0) r_stream_at = cyc;
      if (chk_rdy) begin r_rdy_after_last = pix_ready; chk_rdy = 1'b0; end
      if (chk_glitch) begin
        if (coef_ready !== 1'b0 || pix_ready !== 1'b1 || busy !== 1'b1) r_glitch_err++;
        chk_glitch = 1'b0;
      end
      if (npix == PIXELS && busy === 1'b1 && coef_ready === 1'b0 && pix_ready === 1'b0
          && frame_done === 1'b0) r_drain++;
      if (frame_done === 1'b1) begin
        r_done_seen = 1; r_out_cnt = out_cnt; r_to_at_done = timeout_err; done = 1'b1;
      end
      start = 1'b0; reload_coef = 1'b0;
      f_pix_out_valid = 1'b0;
      if (f_data_valid === 1'b1 && f_data_id === 1'b1 && sent < n_strobes) begin
        f_pix_out_valid = 1'b1;
        sent++;
      end
      coef_valid = 1'b1;
      coef_data  = COFCNT_BIT'($urandom);
      pix_valid  = ($urandom_range(0, 2) != 0);
      pix_data   = PIX_BIT'($urandom);
      pend = 1'b0;
      if (coef_ready === 1'b1) begin
        pend = 1'b1; pend_beat = {1'b0, coef_data};
        r_exp.push_back(pend_beat);
        ncoef++;
        if (ncoef == COEFS) r_last_coef_push = cyc;
      end else if (pix_ready === 1'b1 && pix_valid) begin
        pend = 1'b1; pend_beat = {1'b1, 7'd0, pix_data};
        r_exp.push_back(pend_beat);
        npix++;
        if (npix == PIXELS) chk_rdy = 1'b1;
      end
      if (inject_start && !injected && pix_ready === 1'b1 && npix == 3) begin
        start = 1'b1; reload_coef = 1'b1; injected = 1'b1; chk_glitch = 1'b1;
      end
      if (done) begin coef_valid = 1'b0; pix_valid = 1'b0; f_pix_out_valid = 1'b0; end
      @(negedge clk);
    end
    r_done_after = frame_done;
    r_busy_after = busy;
    coef_valid = 1'b0; pix_valid = 1'b0; f_pix_out_valid = 1'b0;
  endtask

  task automatic test_reset();
    int bad = 0;
    reset_in = 1'b0;
    f_pix_out_valid = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (coef_ready !== 1'b0) begin n_fail++; $display("FAIL reset_coef_ready got %b want 0", coef_ready); end
    n_tests++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL reset_pix_ready got %b want 0", pix_ready); end
    n_tests++; if (f_data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_f_data_valid got %b want 0", f_data_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err got %b want 0", timeout_err); end
    n_tests++; if ({f_data_id, f_data} !== 16'd0) begin n_fail++; $display("FAIL reset_f_data got %h want 0", {f_data_id, f_data}); end
    n_tests++; if (out_cnt !== '0) begin n_fail++; $display("FAIL reset_out_cnt got %0d want 0", out_cnt); end
    reset_in = 1'b1;
    coef_valid = 1'b1; pix_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || f_data_valid !== 1'b0 || out_cnt !== '0) bad++;
    end
    coef_valid = 1'b0; pix_valid = 1'b0; f_pix_out_valid = 1'b0;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL idle_no_activity got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_coef_load();
    run_frame(1'b1, PIXELS, 1'b0);
    n_tests++; if (r_coef_rdy != COEFS) begin n_fail++; $display("FAIL coef_ready_cycles got %0d want %0d", r_coef_rdy, COEFS); end
    n_tests++; if (r_coef_vld != COEFS) begin n_fail++; $display("FAIL coef_beats_id0 got %0d want %0d", r_coef_vld, COEFS); end
    n_tests++; if (r_last_coef - r_first_coef + 1 != COEFS) begin n_fail++; $display("FAIL coef_consecutive got span %0d want %0d", r_last_coef - r_first_coef + 1, COEFS); end
    n_tests++; if (r_stream_at != r_last_coef_push + 1) begin n_fail++; $display("FAIL stream_entry got cycle %0d want %0d", r_stream_at, r_last_coef_push + 1); end
    n_tests++; if (r_obs.size() != COEFS + PIXELS) begin n_fail++; $display("FAIL coef_frame_beats got %0d want %0d", r_obs.size(), COEFS + PIXELS); end
    for (int i = 0; i < r_obs.size() && i < r_exp.size(); i++) begin
      n_tests++; if (r_obs[i] !== r_exp[i]) begin n_fail++; $display("FAIL coef_frame_beat%0d got %h want %h", i, r_obs[i], r_exp[i]); end
    end
    n_tests++; if (r_lat_err != 0) begin n_fail++; $display("FAIL coef_frame_latency got %0d errors want 0", r_lat_err); end
    n_tests++; if (!r_done_seen || r_out_cnt !== 20'(PIXELS)) begin n_fail++; $display("FAIL coef_frame_done got done=%0d out_cnt=%0d want 1/%0d", r_done_seen, r_out_cnt, PIXELS); end
  endtask

  task automatic test_stream_gaps();
    int bad = 0;
    run_frame(1'b0, PIXELS, 1'b0);
    n_tests++; if (r_coef_rdy != 0) begin n_fail++; $display("FAIL nocoef_ready got %0d want 0", r_coef_rdy); end
    n_tests++; if (r_obs.size() != PIXELS) begin n_fail++; $display("FAIL pix_beats got %0d want %0d", r_obs.size(), PIXELS); end
    for (int i = 0; i < r_obs.size() && i < r_exp.size(); i++) begin
      n_tests++; if (r_obs[i] !== r_exp[i]) begin n_fail++; $display("FAIL pix_beat%0d got %h want %h", i, r_obs[i], r_exp[i]); end
    end
    n_tests++; if (r_lat_err != 0) begin n_fail++; $display("FAIL pix_latency got %0d errors want 0", r_lat_err); end
    n_tests++; if (r_rdy_after_last !== 1'b0) begin n_fail++; $display("FAIL pix_ready_after_last got %b want 0", r_rdy_after_last); end
    n_tests++; if (r_done_seen != 1) begin n_fail++; $display("FAIL frame_done_seen got %0d want 1", r_done_seen); end
    n_tests++; if (r_out_cnt !== 20'(PIXELS)) begin n_fail++; $display("FAIL out_cnt_done got %0d want %0d", r_out_cnt, PIXELS); end
    n_tests++; if (r_to_at_done !== 1'b0) begin n_fail++; $display("FAIL no_timeout got %b want 0", r_to_at_done); end
    n_tests++; if (r_done_after !== 1'b0 || r_busy_after !== 1'b0) begin n_fail++; $display("FAIL done_pulse_busy got done=%b busy=%b want 0/0", r_done_after, r_busy_after); end
    f_pix_out_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (out_cnt !== 20'(PIXELS) || busy !== 1'b0) bad++;
    end
    f_pix_out_valid = 1'b0;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL idle_strobe_ignored got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_timeout();
    run_frame(1'b0, PIXELS - 1, 1'b0);
    n_tests++; if (r_done_seen != 1) begin n_fail++; $display("FAIL timeout_done_seen got %0d want 1", r_done_seen); end
    n_tests++; if (r_drain != DRAIN_MAX) begin n_fail++; $display("FAIL drain_cycles got %0d want %0d", r_drain, DRAIN_MAX); end
    n_tests++; if (r_to_at_done !== 1'b1) begin n_fail++; $display("FAIL timeout_set got %b want 1", r_to_at_done); end
    n_tests++; if (r_out_cnt !== 20'(PIXELS - 1)) begin n_fail++; $display("FAIL timeout_out_cnt got %0d want %0d", r_out_cnt, PIXELS - 1); end
    repeat (3) @(negedge clk);
    n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky got %b want 1", timeout_err); end
    run_frame(1'b0, PIXELS, 1'b0);
    n_tests++; if (r_to_after_start !== 1'b0) begin n_fail++; $display("FAIL timeout_clear_on_start got %b want 0", r_to_after_start); end
    n_tests++; if (!r_done_seen || r_to_at_done !== 1'b0) begin n_fail++; $display("FAIL clean_frame_after_timeout got done=%0d to=%b want 1/0", r_done_seen, r_to_at_done); end
  endtask

  task automatic test_reset_mid();
    int npix = 0;
    int bad = 0;
    @(negedge clk);
    start = 1'b1; reload_coef = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 100 && npix < 5; cyc++) begin
      pix_valid = 1'b1; pix_data = PIX_BIT'($urandom);
      if (pix_ready === 1'b1) npix++;
      @(negedge clk);
    end
    pix_valid = 1'b0;
    n_tests++; if (npix != 5 || busy !== 1'b1 || f_data_valid !== 1'b1) begin n_fail++; $display("FAIL mid_frame_reach got pix=%0d busy=%b vld=%b want 5/1/1", npix, busy, f_data_valid); end
    reset_in = 1'b0;
    #1;
    n_tests++; if ({coef_ready, pix_ready, f_data_valid, busy, frame_done, timeout_err} !== 6'd0)
      begin n_fail++; $display("FAIL async_reset_flags got %b want 000000", {coef_ready, pix_ready, f_data_valid, busy, frame_done, timeout_err}); end
    n_tests++; if ({f_data_id, f_data} !== 16'd0 || out_cnt !== '0) begin n_fail++; $display("FAIL async_reset_data got %h/%0d want 0/0", {f_data_id, f_data}, out_cnt); end
    @(negedge clk);
    reset_in = 1'b1;
    pix_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (f_data_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    pix_valid = 1'b0;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL post_reset_idle got %0d bad cycles want 0", bad); end
    run_frame(1'b0, PIXELS, 1'b0);
    n_tests++; if (r_obs.size() != PIXELS) begin n_fail++; $display("FAIL post_reset_beats got %0d want %0d", r_obs.size(), PIXELS); end
    for (int i = 0; i < r_obs.size() && i < r_exp.size(); i++) begin
      n_tests++; if (r_obs[i] !== r_exp[i]) begin n_fail++; $display("FAIL post_reset_beat%0d got %h want %h", i, r_obs[i], r_exp[i]); end
    end
    n_tests++; if (!r_done_seen || r_out_cnt !== 20'(PIXELS)) begin n_fail++; $display("FAIL post_reset_done got done=%0d out_cnt=%0d want 1/%0d", r_done_seen, r_out_cnt, PIXELS); end
  endtask

  task automatic test_start_in_stream();
    run_frame(1'b0, PIXELS, 1'b1);
    n_tests++; if (r_glitch_err != 0) begin n_fail++; $display("FAIL start_in_stream_state got %0d errors want 0", r_glitch_err); end
    n_tests++; if (r_coef_rdy != 0) begin n_fail++; $display("FAIL start_in_stream_coef got %0d ready cycles want 0", r_coef_rdy); end
    n_tests++; if (r_obs.size() != PIXELS) begin n_fail++; $display("FAIL start_in_stream_beats got %0d want %0d", r_obs.size(), PIXELS); end
    for (int i = 0; i < r_obs.size() && i < r_exp.size(); i++) begin
      n_tests++; if (r_obs[i] !== r_exp[i]) begin n_fail++; $display("FAIL start_in_stream_beat%0d got %h want %h", i, r_obs[i], r_exp[i]); end
    end
    n_tests++; if (!r_done_seen || r_out_cnt !== 20'(PIXELS)) begin n_fail++; $display("FAIL start_in_stream_done got done=%0d out_cnt=%0d want 1/%0d", r_done_seen, r_out_cnt, PIXELS); end
  endtask

  initial begin
    reset_in = 1'b0; start = 1'b0; reload_coef = 1'b0;
    coef_valid = 1'b0; coef_data = '0; pix_valid = 1'b0; pix_data = '0;
    f_pix_out_valid = 1'b0;
    test_reset();
    test_coef_load();
    test_stream_gaps();
    test_timeout();
    test_reset_mid();
    test_start_in_stream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
